fft_frame_scheduler: RTL and testbench

- Front-end sequencer for the cascaded radix-2 FFT stage chain (first stage consumes start/over framing pulses plus 32-bit real/img samples).
- Accepts samples over a valid/ready stream, cuts them into N-point frames and generates the first-stage start/over pulses.
- Enforces an inter-frame gap and limits the number of frames in flight.
- Tracks last-stage start_next/end_next to produce output-frame valid/first/last and length-error flags.

---
 rtl/fft_sched_pkg.sv | 20 ++
 rtl/fft_frame_scheduler_if.sv | 30 +++
 rtl/fft_out_tracker.sv | 79 +++++++
 rtl/fft_frame_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fft_sched_pkg
// Brief  : Shared widths and FSM state type for the FFT frame scheduler.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package fft_sched_pkg;

  localparam int DATA_W    = 32;
  localparam int LOG2N_DEF = 13;
  localparam int FCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_frame_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fft_frame_scheduler_if
// Brief  : Input sample stream and first-stage sample/framing bus.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface fft_frame_scheduler_if;
  import fft_sched_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_img;
  logic              fft_start;
  logic              fft_over;
  logic [DATA_W-1:0] fft_real;
  logic [DATA_W-1:0] fft_img;

  modport slave (
    input  s_valid, s_real, s_img,
    output s_ready, fft_start, fft_over, fft_real, fft_img
  );

  modport master (
    output s_valid, s_real, s_img,
    input  s_ready, fft_start, fft_over, fft_real, fft_img
  );

endinterface
`default_nettype wire

// File: rtl/fft_out_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fft_out_tracker
// Brief  : Frames the chain output from done_start/done_end, flags bad lengths.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module fft_out_tracker
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic flush,
  input  wire logic enable,
  input  wire logic done_start,
  input  wire logic done_end,
  output logic      m_valid,
  output logic      m_first,
  output logic      m_last,
  output logic      len_err
);

  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  logic             open_q, open_d;
  logic [LOG2N-1:0] ocnt_q, ocnt_d;

  // ocnt_q holds the index of the sample presented in the current open cycle.
  always_comb begin
    open_d  = open_q;
    ocnt_d  = ocnt_q;
    m_valid = 1'b0;
    m_first = 1'b0;
    m_last  = 1'b0;
    len_err = 1'b0;
    if (enable) begin
      if (done_start) begin
        m_valid = 1'b1;
        m_first = 1'b1;
        len_err = open_q;
        if (done_end) begin
          m_last  = 1'b1;
          len_err = 1'b1;
          open_d  = 1'b0;
          ocnt_d  = '0;
        end else begin
          open_d  = 1'b1;
          ocnt_d  = LOG2N'(1);
        end
      end else if (open_q) begin
        m_valid = 1'b1;
        ocnt_d  = ocnt_q + 1'b1;
        if (done_end) begin
          m_last  = 1'b1;
          open_d  = 1'b0;
          len_err = (ocnt_q != LAST_IDX);
        end
      end else if (done_end) begin
        len_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      open_q <= 1'b0;
      ocnt_q <= '0;
    end else if (flush) begin
      open_q <= 1'b0;
      ocnt_q <= '0;
    end else begin
      open_q <= open_d;
      ocnt_q <= ocnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fft_frame_scheduler
// Brief  : Cuts a sample stream into N-point frames for the FFT stage chain,
//          enforces inter-frame gap / in-flight limit. Option: FFT_SCHED_FRAME_CNT_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int LOG2N        = LOG2N_DEF,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  input  wire logic            flush,
  fft_frame_scheduler_if.slave bus,
  input  wire logic            done_start,
  input  wire logic            done_end,
  output logic                 m_valid,
  output logic                 m_first,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_underrun,
  output logic                 err_len,
  output logic [FCNT_W-1:0]    frames_in,
  output logic [FCNT_W-1:0]    frames_out
);

  localparam int               GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]       INF_MAX  = 3'(MAX_INFLIGHT);
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  sched_state_e      state_q, state_d;
  logic [LOG2N-1:0]  idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [2:0]        inflight_q, inflight_d;
  logic              rdy_en_q;
  logic              start_q, start_d, over_q, over_d;
  logic [DATA_W-1:0] re_q, re_d, im_q, im_d;
  logic              und_q, und_d, len_q, len_d;
  logic              issue, unexp_end, s_ready, trk_len_err;

  // rdy_en_q keeps s_ready low while in reset and releases it on the first clock.
  assign s_ready = rdy_en_q &&
                   (((state_q == IDLE) && (inflight_q < INF_MAX)) || (state_q == LOAD));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    start_d = 1'b0;
    over_d  = 1'b0;
    re_d    = '0;
    im_d    = '0;
    und_d   = und_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready) begin
          state_d = LOAD;
          idx_d   = LOG2N'(1);
          start_d = 1'b1;
          re_d    = bus.s_real;
          im_d    = bus.s_img;
        end
      end
      LOAD: begin
        // The chain needs contiguous data: a missing sample becomes zero.
        if (bus.s_valid) begin
          re_d = bus.s_real;
          im_d = bus.s_img;
        end else begin
          und_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          over_d  = 1'b1;
          issue   = 1'b1;
          state_d = GAP;
          gap_d   = GAP_LOAD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    unexp_end  = 1'b0;
    if (issue && !done_end) begin
      inflight_d = inflight_q + 1'b1;
    end else if (done_end && !issue) begin
      if (inflight_q == '0) unexp_end  = 1'b1;
      else                  inflight_d = inflight_q - 1'b1;
    end
    len_d = len_q | trk_len_err | unexp_end;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      inflight_q <= '0;
      rdy_en_q   <= 1'b0;
      start_q    <= 1'b0;
      over_q     <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      und_q      <= 1'b0;
      len_q      <= 1'b0;
    end else if (flush) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      inflight_q <= '0;
      rdy_en_q   <= 1'b1;
      start_q    <= 1'b0;
      over_q     <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      und_q      <= 1'b0;
      len_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      inflight_q <= inflight_d;
      rdy_en_q   <= 1'b1;
      start_q    <= start_d;
      over_q     <= over_d;
      re_q       <= re_d;
      im_q       <= im_d;
      und_q      <= und_d;
      len_q      <= len_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.fft_start = start_q;
  assign bus.fft_over  = over_q;
  assign bus.fft_real  = re_q;
  assign bus.fft_img   = im_q;
  assign busy          = (state_q != IDLE) || (inflight_q != '0);
  assign err_underrun  = und_q;
  assign err_len       = len_q;

  fft_out_tracker #(.LOG2N(LOG2N)) u_trk (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .enable     (rdy_en_q),
    .done_start (done_start),
    .done_end   (done_end),
    .m_valid    (m_valid),
    .m_first    (m_first),
    .m_last     (m_last),
    .len_err    (trk_len_err)
  );

`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [FCNT_W-1:0] fin_q, fout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fin_q  <= '0;
      fout_q <= '0;
    end else if (flush) begin
      fin_q  <= '0;
      fout_q <= '0;
    end else begin
      if (issue)    fin_q  <= fin_q + 1'b1;
      if (done_end) fout_q <= fout_q + 1'b1;
    end
  end

  assign frames_in  = fin_q;
  assign frames_out = fout_q;
`else
  assign frames_in  = '0;
  assign frames_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_fft_frame_scheduler
// Brief  : Directed/randomized self-checking bench for fft_frame_scheduler.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_fft_frame_scheduler;
  import fft_sched_pkg::*;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int GAP   = 4;
  localparam int MAXF  = 2;

  logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic        done_start = 1'b0, done_end = 1'b0;
  logic        m_valid, m_first, m_last, busy, err_underrun, err_len;
  logic [15:0] frames_in, frames_out;

  int checks = 0, errors = 0;
  int inflight_m = 0, fin_m = 0, fout_m = 0;
  bit exp_len = 1'b0, exp_und = 1'b0;

  fft_frame_scheduler_if bus ();

  fft_frame_scheduler #(.LOG2N(LOG2N), .GAP_CYCLES(GAP), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus),
    .done_start(done_start), .done_end(done_end),
    .m_valid(m_valid), .m_first(m_first), .m_last(m_last), .busy(busy),
    .err_underrun(err_underrun), .err_len(err_len),
    .frames_in(frames_in), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bus.s_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk("ready_timeout", 64'(w < 100), 64'd1);
  endtask

  // Drives one N-sample frame; slot 'drop' is left invalid (underrun).
  task automatic send_frame(input int drop, input bit with_done, input bit seq);
    logic [31:0] re, im;
    bit v;
    wait_ready();
    for (int k = 0; k < N; k++) begin
      v  = (k != drop);
      re = seq ? 32'(k + 1) : $urandom;
      im = $urandom;
      bus.s_valid = v; bus.s_real = re; bus.s_img = im;
      done_start = with_done && (k == 0);
      done_end   = with_done && (k == N - 1);
      tick();
      bus.s_valid = 1'b0; done_start = 1'b0; done_end = 1'b0;
      chk("fft_real",  bus.fft_real,  v ? re : 32'd0);
      chk("fft_img",   bus.fft_img,   v ? im : 32'd0);
      chk("fft_start", bus.fft_start, 64'(k == 0));
      chk("fft_over",  bus.fft_over,  64'(k == N - 1));
      if (k < N - 1) chk("load_rdy", bus.s_ready, 1);
    end
    if (drop >= 0) exp_und = 1'b1;
    if (!with_done) inflight_m++;
    else fout_m++;
    fin_m++;
    chk("err_underrun", err_underrun, exp_und);
  endtask

  task automatic check_gap();
    for (int g = 0; g < GAP; g++) begin
      chk("gap_rdy", bus.s_ready, 0);
      tick();
    end
    chk("post_gap_rdy", bus.s_ready, 64'(inflight_m < MAXF));
  endtask

  // Chain-output frame of 'len' cycles from done_start to done_end inclusive.
  task automatic out_frame(input int len);
    for (int i = 0; i < len; i++) begin
      done_start = (i == 0);
      done_end   = (i == len - 1);
      #1;
      chk("m_valid", m_valid, 1);
      chk("m_first", m_first, 64'(i == 0));
      chk("m_last",  m_last,  64'(i == len - 1));
      tick();
      done_start = 1'b0; done_end = 1'b0;
    end
    if (len != N) exp_len = 1'b1;
    if (inflight_m == 0) exp_len = 1'b1;
    else inflight_m--;
    fout_m++;
    #1;
    chk("m_valid_idle", m_valid, 0);
    chk("err_len", err_len, exp_len);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    inflight_m = 0; fin_m = 0; fout_m = 0; exp_len = 1'b0; exp_und = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_errs", {err_len, err_underrun}, 0);
    chk("flush_over", bus.fft_over, 0);
  endtask

  initial begin
    int over_seen;
    int len;
    bus.s_valid = 1'b0; bus.s_real = '0; bus.s_img = '0;

    tick(); tick();
    chk("rst_data", {bus.fft_real, bus.fft_img}, 0);
    chk("rst_ctl", {bus.fft_start, bus.fft_over, bus.s_ready, busy, m_valid, m_first,
                    m_last, err_underrun, err_len, frames_in, frames_out}, 0);
    rstn = 1'b1;
    chk("rel_rdy_low", bus.s_ready, 0);
    tick();
    chk("rel_rdy", bus.s_ready, 1);
    chk("rel_busy", busy, 0);

    // Asynchronous reset in the middle of a frame.
    bus.s_valid = 1'b1; bus.s_real = 32'hA5A5_0001; bus.s_img = $urandom;
    tick(); tick(); tick();
    bus.s_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("arst_data", {bus.fft_real, bus.fft_img}, 0);
    chk("arst_ctl", {bus.fft_start, bus.fft_over, bus.s_ready, busy, err_underrun, err_len}, 0);
    #1;
    rstn = 1'b1;
    chk("arst_rdy_low", bus.s_ready, 0);
    tick();
    chk("arst_rdy", bus.s_ready, 1);

    // Basic frame, then in-flight limit.
    send_frame(-1, 1'b0, 1'b1);
    check_gap();
    send_frame(-1, 1'b0, 1'b0);
    check_gap();
    tick();
    chk("limit_hold", bus.s_ready, 0);
    chk("limit_busy", busy, 1);
    out_frame(N);
    chk("limit_release", bus.s_ready, 1);

    // Third frame with a one-slot underrun at idx 3.
    send_frame(3, 1'b0, 1'b0);
    check_gap();

    // Short output frame, then flush clears errors.
    out_frame(6);
    do_flush();
    send_frame(-1, 1'b0, 1'b0);
    check_gap();
    out_frame(N);

    // Frame issue coinciding with done_end keeps inflight unchanged.
    send_frame(-1, 1'b0, 1'b0);
    check_gap();
    send_frame(-1, 1'b1, 1'b0);
    check_gap();
    send_frame(-1, 1'b0, 1'b0);
    check_gap();
    chk("simul_err_len", err_len, exp_len);

    // Flush mid-LOAD: no over pulse may follow.
    do_flush();
    bus.s_valid = 1'b1; bus.s_real = $urandom; bus.s_img = $urandom;
    tick(); tick(); tick();
    bus.s_valid = 1'b0;
    do_flush();
    over_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.fft_over === 1'b1) over_seen++;
      tick();
    end
    chk("flush_no_over", 64'(over_seen), 0);

    // Frame counters.
    send_frame(-1, 1'b0, 1'b0);
    check_gap();
    send_frame(-1, 1'b1, 1'b0);
    check_gap();
    send_frame(-1, 1'b1, 1'b0);
    check_gap();
`ifdef FFT_SCHED_FRAME_CNT_EN
    chk("frames_in",  frames_in,  64'(fin_m));
    chk("frames_out", frames_out, 64'(fout_m));
`else
    chk("frames_in_off",  frames_in,  0);
    chk("frames_out_off", frames_out, 0);
`endif

    // Random-length output frame against the length rule.
    len = $urandom_range(2, 12);
    out_frame(len);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
